dmem_responder: RTL and testbench

Data-memory responder serving the CPU's memory stage. It answers word-granular load/store requests with a combinational read path and a clocked, byte-strobed write path. It sits outside the pipeline, directly on the memory stage's `mem_we`/`mem_re`/address/read-data interface. An optional memory-mapped I/O window provides a simulation `tohost` register and a 64-bit cycle counter.

---
 rtl/dmem_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Purpose: word-granular data-memory responder for the CPU memory stage, with optional MMIO window.
// Latency: loads are combinational (same cycle); stores and flag updates land at the next rising edge.
// Backpressure: none; every request is accepted in the cycle it is presented.
//
// Optional feature macro: DMEM_MMIO_EN (tohost register, 64-bit cycle counter, hi_shadow).
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   mem_we / mem_re       - store / load request this cycle
//   mem_rd_addr           - byte address for both loads and stores
//   mem_wr_data/mem_wstrb - store data and little-endian byte enables
//   mem_rd_data, mem_err  - combinational load data and fault indication
//   err_sticky            - latched fault flag, cleared only by reset
//   tohost_valid/_data    - simulation tohost register (zero when MMIO is compiled out)
module dmem_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_wr_data,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rd_data,
  output logic        mem_err,
  output logic        err_sticky,
  output logic        tohost_valid,
  output logic [31:0] tohost_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  // One extra bit so DEPTH*4 == 2^32 still compares correctly.
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;

  logic [31:0]   ram_q [DEPTH];
  logic [31:0]   offset;
  logic          ram_hit;
  logic [AW-1:0] word_idx;
  logic          mmio_hit;
  logic [31:0]   mmio_rdata;
  logic          req;
  logic          fault;
  logic [31:0]   wmask;
  logic          ram_we;
  logic          err_sticky_q, err_sticky_d;

  // Wrap-around subtraction: addresses below BASE_ADDR become huge offsets and miss.
  always_comb begin
    offset   = mem_rd_addr - BASE_ADDR;
    ram_hit  = ({1'b0, offset} < RAM_BYTES);
    word_idx = offset[AW+1:2];
  end

  assign req   = mem_we | mem_re;
  assign fault = req & ((mem_rd_addr[1:0] != 2'b00) | ~(ram_hit | mmio_hit));
  assign wmask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
  // RAM decode wins if a RAM placement ever overlaps the MMIO window.
  assign ram_we = mem_we & ram_hit & ~fault;

  // The read mux sees the pre-edge array, so a same-cycle store shows old data.
  always_comb begin
    mem_rd_data = 32'h0;
    if (mem_re && !fault) begin
      mem_rd_data = ram_hit ? ram_q[word_idx] : mmio_rdata;
    end
  end

  assign mem_err = fault;

  // RAM is not reset; gating with rst_n drops a store whose edge lands while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && ram_we) begin
      ram_q[word_idx] <= (ram_q[word_idx] & ~wmask) | (mem_wr_data & wmask);
    end
  end

  assign err_sticky_d = err_sticky_q | fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;

`ifdef DMEM_MMIO_EN
  localparam logic [31:0] TOHOST_ADDR   = 32'hFFFF_FF00;
  localparam logic [31:0] CYCLE_LO_ADDR = 32'hFFFF_FF04;
  localparam logic [31:0] CYCLE_HI_ADDR = 32'hFFFF_FF08;

  logic        hit_tohost, hit_lo, hit_hi;
  logic [31:0] tohost_q, tohost_d;
  logic        tohost_vld_q, tohost_vld_d;
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;

  assign hit_tohost = (mem_rd_addr == TOHOST_ADDR);
  assign hit_lo     = (mem_rd_addr == CYCLE_LO_ADDR);
  assign hit_hi     = (mem_rd_addr == CYCLE_HI_ADDR);
  assign mmio_hit   = hit_tohost | hit_lo | hit_hi;

  always_comb begin
    mmio_rdata = 32'h0;
    if (hit_tohost) mmio_rdata = tohost_q;
    else if (hit_lo) mmio_rdata = cycle_q[31:0];
    else if (hit_hi) mmio_rdata = hi_shadow_q;
  end

  always_comb begin
    tohost_d     = tohost_q;
    tohost_vld_d = tohost_vld_q;
    hi_shadow_d  = hi_shadow_q;
    cycle_d      = cycle_q + 64'd1;
    if (mem_we && hit_tohost && !ram_hit && !fault) begin
      tohost_d     = (tohost_q & ~wmask) | (mem_wr_data & wmask);
      tohost_vld_d = tohost_vld_q | (mem_wstrb != 4'h0);
    end
    // Latching the upper half on the low read gives software a coherent 64-bit snapshot.
    if (mem_re && hit_lo && !ram_hit && !fault) begin
      hi_shadow_d = cycle_q[63:32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tohost_q     <= 32'h0;
      tohost_vld_q <= 1'b0;
      cycle_q      <= 64'h0;
      hi_shadow_q  <= 32'h0;
    end else begin
      tohost_q     <= tohost_d;
      tohost_vld_q <= tohost_vld_d;
      cycle_q      <= cycle_d;
      hi_shadow_q  <= hi_shadow_d;
    end
  end

  assign tohost_valid = tohost_vld_q;
  assign tohost_data  = tohost_q;
`else
  assign mmio_hit     = 1'b0;
  assign mmio_rdata   = 32'h0;
  assign tohost_valid = 1'b0;
  assign tohost_data  = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Purpose: randomized scoreboard bench for dmem_responder against a behavioural memory model.
// Latency: expectations are queued at drive time and popped by a monitor on the falling edge.
// Backpressure: none; the responder answers every cycle.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam logic [31:0] RAM_END = BASE + DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_we, mem_re;
  logic [31:0] mem_rd_addr, mem_wr_data;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rd_data;
  logic        mem_err, err_sticky, tohost_valid;
  logic [31:0] tohost_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_rd_addr(mem_rd_addr), .mem_wr_data(mem_wr_data), .mem_wstrb(mem_wstrb),
    .mem_rd_data(mem_rd_data), .mem_err(mem_err), .err_sticky(err_sticky),
    .tohost_valid(tohost_valid), .tohost_data(tohost_data)
  );

  typedef struct {
    logic [31:0] rd;
    bit          chk_rd;
    bit          err;
    bit          sticky;
    bit          tvld;
    logic [31:0] tdata;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [31:0]     m_mem [DEPTH];
  bit              m_known [DEPTH];
  bit              m_sticky;
  logic [31:0]     m_tohost;
  bit              m_tvld;
  longint unsigned m_cyc;
  logic [31:0]     m_hi;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_mmio(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
    return (a == 32'hFFFF_FF00) || (a == 32'hFFFF_FF04) || (a == 32'hFFFF_FF08);
`else
    return 1'b0;
`endif
  endfunction

  // Called just after a rising edge; drives one request, queues its expectation,
  // then advances the model across the next rising edge.
  task automatic do_cycle(input bit we, input bit re, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    logic [31:0] off;
    bit in_ram, fault;
    int unsigned idx;
    mem_we = we; mem_re = re; mem_rd_addr = addr; mem_wr_data = data; mem_wstrb = strb;
    off    = addr - BASE;
    in_ram = (off < DEPTH * 4);
    idx    = off / 4;
    fault  = (we || re) && ((addr % 4) != 0 || !(in_ram || is_mmio(addr)));
    e.rd = 32'h0; e.chk_rd = 1'b1;
    e.err = fault; e.sticky = m_sticky; e.tvld = m_tvld; e.tdata = m_tohost;
    if (re && !fault) begin
      if (in_ram) begin
        e.rd = m_mem[idx];
        e.chk_rd = m_known[idx];
      end else if (addr == 32'hFFFF_FF00) e.rd = m_tohost;
      else if (addr == 32'hFFFF_FF04) e.rd = m_cyc[31:0];
      else e.rd = m_hi;
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      if (fault) m_sticky = 1'b1;
      else begin
        if (we && in_ram) begin
          m_mem[idx] = merge(m_mem[idx], data, strb);
          if (strb != 4'hF && !m_known[idx]) m_known[idx] = 1'b0;
          else m_known[idx] = 1'b1;
        end
        if (we && addr == 32'hFFFF_FF00 && is_mmio(addr)) begin
          m_tohost = merge(m_tohost, data, strb);
          if (strb != 4'h0) m_tvld = 1'b1;
        end
        if (re && addr == 32'hFFFF_FF04 && is_mmio(addr)) m_hi = m_cyc[63:32];
      end
      m_cyc++;
    end
    #1;
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic model_reset();
    m_sticky = 1'b0; m_tohost = 32'h0; m_tvld = 1'b0; m_cyc = 0; m_hi = 32'h0;
  endtask

  // Asserts reset off-edge, checks cleared state, releases on a falling edge and
  // returns just after the first rising edge out of reset.
  task automatic reset_pulse();
    mem_we = 1'b0; mem_re = 1'b0; mem_wstrb = 4'h0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_err_sticky", {31'h0, err_sticky}, 32'h0);
    check("rst_mem_err", {31'h0, mem_err}, 32'h0);
    check("rst_rd_data", mem_rd_data, 32'h0);
    check("rst_tohost_valid", {31'h0, tohost_valid}, 32'h0);
    check("rst_tohost_data", tohost_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    m_cyc = 1;
    #1;
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mem_err", {31'h0, mem_err}, {31'h0, e.err});
        if (e.chk_rd) check("mem_rd_data", mem_rd_data, e.rd);
        check("err_sticky", {31'h0, err_sticky}, {31'h0, e.sticky});
        check("tohost_valid", {31'h0, tohost_valid}, {31'h0, e.tvld});
        check("tohost_data", tohost_data, e.tdata);
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int unsigned k, sel;
    mem_we = 1'b0; mem_re = 1'b0; mem_rd_addr = 32'h0; mem_wr_data = 32'h0; mem_wstrb = 4'h0;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 32'h0; m_known[i] = 1'b0; end
    rst_n = 1'b1;
    #2;
    reset_pulse();

    // Fill the words the random phase touches so every read has a defined value.
    for (int i = 0; i < 16; i++) begin
      do_cycle(1'b1, 1'b0, BASE + 4 * i, $urandom, 4'hF);
      do_cycle(1'b1, 1'b0, BASE + 4 * (DEPTH - 16 + i), $urandom, 4'hF);
    end

    // Directed scenarios
    do_cycle(1'b1, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    do_cycle(1'b0, 1'b1, BASE + 32'h10, 32'h0, 4'h0);
    do_cycle(1'b1, 1'b0, BASE + 32'h10, 32'h0000_00AA, 4'b0001);
    do_cycle(1'b0, 1'b1, BASE + 32'h10, 32'h0, 4'h0);
    do_cycle(1'b1, 1'b0, BASE + 32'h10, 32'hFFFF_FFFF, 4'h0);
    do_cycle(1'b0, 1'b1, BASE + 32'h10, 32'h0, 4'h0);
    do_cycle(1'b1, 1'b1, BASE + 32'h10, 32'h1234_5678, 4'b1100);
    do_cycle(1'b0, 1'b1, BASE + 32'h10, 32'h0, 4'h0);
    do_cycle(1'b0, 1'b1, BASE + 32'h12, 32'h0, 4'h0);
    idle();
    do_cycle(1'b1, 1'b0, RAM_END, 32'hCAFE_F00D, 4'hF);
    do_cycle(1'b0, 1'b1, BASE + 4 * (DEPTH - 1), 32'h0, 4'h0);
    do_cycle(1'b1, 1'b0, 32'hFFFF_FF00, 32'h0000_0001, 4'hF);
    idle();
    do_cycle(1'b0, 1'b1, 32'hFFFF_FF04, 32'h0, 4'h0);
    do_cycle(1'b0, 1'b1, 32'hFFFF_FF08, 32'h0, 4'h0);
    do_cycle(1'b1, 1'b0, 32'hFFFF_FF04, 32'h5555_5555, 4'hF);
    idle();

    // Mid-run reset clears flags; a store held across a reset edge is dropped.
    reset_pulse();
    rst_n = 1'b0;
    model_reset();
    mem_we = 1'b1; mem_re = 1'b0; mem_rd_addr = BASE + 32'h10;
    mem_wr_data = 32'h0BAD_0BAD; mem_wstrb = 4'hF;
    @(posedge clk);
    #1;
    mem_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    m_cyc = 1;
    #1;
    do_cycle(1'b0, 1'b1, BASE + 32'h10, 32'h0, 4'h0);

    // Random phase
    for (int n = 0; n < 2000; n++) begin
      sel = $urandom_range(0, 9);
      k   = $urandom_range(0, 15);
      case (sel)
        0, 1, 2: a = BASE + 4 * k;
        3, 4, 5: a = BASE + 4 * (DEPTH - 16 + k);
        6:       a = BASE + 4 * k + $urandom_range(1, 3);
        7:       a = RAM_END + 4 * k;
        8:       a = BASE - 4 * (k + 1);
        default: a = 32'hFFFF_FF00 + 4 * (k % 4);
      endcase
      d = $urandom;
      do_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, d, 4'($urandom));
    end
    idle();

    // Drain with a bounded wait.
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
